// File: rtl/mc_cmd_issuer.sv
// DDR4 command issuer: open-page bank table, one shared wait counter for
// tRCD/tRP/tRFC, and a periodic refresh that never preempts an accepted request.
module mc_cmd_issuer #(
   parameter int RANKS     = 1,
   parameter int BGWIDTH   = 2,
   parameter int BAWIDTH   = 2,
   parameter int ADDRWIDTH = 17,
   parameter int COLWIDTH  = 10,
   parameter int TRCD      = 4,
   parameter int TRP       = 4,
   parameter int TRFC      = 8,
   parameter int TREFI     = 64,
   localparam int RKW      = (RANKS > 1) ? $clog2(RANKS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [RKW-1:0]       req_rank,
   input  logic [BGWIDTH-1:0]   req_bg,
   input  logic [BAWIDTH-1:0]   req_ba,
   input  logic [ADDRWIDTH-1:0] req_row,
   input  logic [COLWIDTH-1:0]  req_col,
   output logic                 act_n,
   output logic [ADDRWIDTH-1:0] A,
   output logic [BGWIDTH-1:0]   bg,
   output logic [BAWIDTH-1:0]   ba,
   output logic [RANKS-1:0]     cs_n,
   output logic                 cke,
   output logic                 rsp_valid,
   output logic                 rsp_we
);

   localparam int IW    = RKW + BGWIDTH + BAWIDTH;
   localparam int NENT  = 2 ** IW;
   localparam int CW    = 16;
   localparam int TW    = (TREFI > 1) ? $clog2(TREFI) : 1;
   localparam int A_RAS = 16;
   localparam int A_CAS = 15;
   localparam int A_WE  = 14;
   localparam int A_AP  = 10;

   typedef enum logic [3:0] {
      ST_IDLE, ST_PRE, ST_WAIT_RP, ST_ACT, ST_WAIT_RCD,
      ST_RDWR, ST_REF_PRA, ST_WAIT_RP_REF, ST_REF, ST_WAIT_RFC
   } state_t;

   state_t                 state_r, state_s;
   logic [CW-1:0]          cnt_r, cnt_s;
   logic                   accept_s;
   logic                   we_r;
   logic [RKW-1:0]         rank_r;
   logic [BGWIDTH-1:0]     bg_req_r;
   logic [BAWIDTH-1:0]     ba_req_r;
   logic [ADDRWIDTH-1:0]   row_r;
   logic [COLWIDTH-1:0]    col_r;
   logic [NENT-1:0]        valid_r;
   logic [ADDRWIDTH-1:0]   row_tab_r [NENT];
   logic [TW-1:0]          timer_r;
   logic                   ref_pend_r;
   logic                   wrap_s;
   logic [IW-1:0]          req_idx_s, cur_idx_s;
   logic                   req_open_s, req_hit_s;
   logic [RANKS-1:0]       bank_cs_s;
   logic                   act_n_r, act_n_s;
   logic [ADDRWIDTH-1:0]   a_r, a_s;
   logic [BGWIDTH-1:0]     bg_r, bg_s;
   logic [BAWIDTH-1:0]     ba_r, ba_s;
   logic [RANKS-1:0]       cs_n_r, cs_n_s;
   logic                   cke_r;
   logic                   rsp_valid_r, rsp_valid_s;
   logic                   rsp_we_r, rsp_we_s;

   assign req_idx_s  = {req_rank, req_bg, req_ba};
   assign cur_idx_s  = {rank_r, bg_req_r, ba_req_r};
   assign req_open_s = valid_r[req_idx_s];
   assign req_hit_s  = (row_tab_r[req_idx_s] == req_row);
   assign wrap_s     = (timer_r == TW'(TREFI - 1));
   assign req_ready  = (state_r == ST_IDLE) && !ref_pend_r && cke_r;

   assign act_n     = act_n_r;
   assign A         = a_r;
   assign bg        = bg_r;
   assign ba        = ba_r;
   assign cs_n      = cs_n_r;
   assign cke       = cke_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_we    = rsp_we_r;

   // Chip-select pattern for a bank command to the captured rank.
   always_comb begin
      bank_cs_s = {RANKS{1'b1}};
      for (int i = 0; i < RANKS; i++) begin
         bank_cs_s[i] = (rank_r != RKW'(i));
      end
   end

   // Next-state, shared wait counter and next command bus.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      accept_s    = 1'b0;
      act_n_s     = 1'b1;
      a_s         = {ADDRWIDTH{1'b1}};
      bg_s        = bg_r;
      ba_s        = ba_r;
      cs_n_s      = {RANKS{1'b1}};
      rsp_valid_s = 1'b0;
      rsp_we_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ref_pend_r) begin
               state_s = (|valid_r) ? ST_REF_PRA : ST_REF;
            end else if (req_valid && cke_r) begin
               accept_s = 1'b1;
               if (req_open_s && req_hit_s) begin
                  state_s = ST_RDWR;
               end else if (req_open_s) begin
                  state_s = ST_PRE;
               end else begin
                  state_s = ST_ACT;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_PRE: begin
            a_s[A_RAS] = 1'b0;
            a_s[A_CAS] = 1'b1;
            a_s[A_WE]  = 1'b0;
            a_s[A_AP]  = 1'b0;
            bg_s       = bg_req_r;
            ba_s       = ba_req_r;
            cs_n_s     = bank_cs_s;
            cnt_s      = CW'(TRP - 2);
            state_s    = ST_WAIT_RP;
         end
         ST_WAIT_RP: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_ACT;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_ACT: begin
            act_n_s = 1'b0;
            a_s     = row_r;
            bg_s    = bg_req_r;
            ba_s    = ba_req_r;
            cs_n_s  = bank_cs_s;
            cnt_s   = CW'(TRCD - 2);
            state_s = ST_WAIT_RCD;
         end
         ST_WAIT_RCD: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_RDWR;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_RDWR: begin
            a_s[COLWIDTH-1:0] = col_r;
            a_s[A_RAS]  = 1'b1;
            a_s[A_CAS]  = 1'b0;
            a_s[A_WE]   = !we_r;
            a_s[A_AP]   = 1'b0;
            bg_s        = bg_req_r;
            ba_s        = ba_req_r;
            cs_n_s      = bank_cs_s;
            rsp_valid_s = 1'b1;
            rsp_we_s    = we_r;
            state_s     = ST_IDLE;
         end
         ST_REF_PRA: begin
            a_s[A_RAS] = 1'b0;
            a_s[A_CAS] = 1'b1;
            a_s[A_WE]  = 1'b0;
            a_s[A_AP]  = 1'b1;
            cs_n_s     = {RANKS{1'b0}};
            cnt_s      = CW'(TRP - 2);
            state_s    = ST_WAIT_RP_REF;
         end
         ST_WAIT_RP_REF: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_REF;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         ST_REF: begin
            a_s[A_RAS] = 1'b0;
            a_s[A_CAS] = 1'b0;
            a_s[A_WE]  = 1'b1;
            cs_n_s     = {RANKS{1'b0}};
            cnt_s      = CW'(TRFC - 1);
            state_s    = ST_WAIT_RFC;
         end
         ST_WAIT_RFC: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r - CW'(1);
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register and shared wait counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Request fields held for the whole command sequence.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we_r     <= 1'b0;
         rank_r   <= {RKW{1'b0}};
         bg_req_r <= {BGWIDTH{1'b0}};
         ba_req_r <= {BAWIDTH{1'b0}};
         row_r    <= {ADDRWIDTH{1'b0}};
         col_r    <= {COLWIDTH{1'b0}};
      end else if (accept_s) begin
         we_r     <= req_we;
         rank_r   <= req_rank;
         bg_req_r <= req_bg;
         ba_req_r <= req_ba;
         row_r    <= req_row;
         col_r    <= req_col;
      end
   end

   // Open-row table, updated in the cycle the ACT/PRE/PRA goes out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_r <= {NENT{1'b0}};
         for (int i = 0; i < NENT; i++) begin
            row_tab_r[i] <= {ADDRWIDTH{1'b0}};
         end
      end else begin
         case (state_r)
            ST_ACT: begin
               valid_r[cur_idx_s]   <= 1'b1;
               row_tab_r[cur_idx_s] <= row_r;
            end
            ST_PRE:     valid_r[cur_idx_s] <= 1'b0;
            ST_REF_PRA: valid_r <= {NENT{1'b0}};
            default: ;
         endcase
      end
   end

   // Refresh interval timer; a wrap while already pending is absorbed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         timer_r    <= {TW{1'b0}};
         ref_pend_r <= 1'b0;
      end else begin
         timer_r <= wrap_s ? {TW{1'b0}} : timer_r + TW'(1);
         if (wrap_s) begin
            ref_pend_r <= 1'b1;
         end else if (state_r == ST_REF) begin
            ref_pend_r <= 1'b0;
         end
      end
   end

   // Registered DDR command bus and response pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         act_n_r     <= 1'b1;
         a_r         <= {ADDRWIDTH{1'b1}};
         bg_r        <= {BGWIDTH{1'b0}};
         ba_r        <= {BAWIDTH{1'b0}};
         cs_n_r      <= {RANKS{1'b1}};
         cke_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_we_r    <= 1'b0;
      end else begin
         act_n_r     <= act_n_s;
         a_r         <= a_s;
         bg_r        <= bg_s;
         ba_r        <= ba_s;
         cs_n_r      <= cs_n_s;
         cke_r       <= 1'b1;
         rsp_valid_r <= rsp_valid_s;
         rsp_we_r    <= rsp_we_s;
      end
   end

endmodule

// File: tb/tb_mc_cmd_issuer.sv
// Cycle-indexed directed bench for mc_cmd_issuer: stimulus and expected
// command, ready, cke and bank tables are filled first, then compared each cycle.
module tb_mc_cmd_issuer;

   localparam int B    = 3;
   localparam int NCYC = B + 176;
   localparam int C_DESEL = 0, C_ACT = 1, C_PRE = 2, C_PRA = 3;
   localparam int C_RD = 4, C_WR = 5, C_REF = 6, C_BAD = 7;

   logic        clk = 1'b0;
   logic        reset_n, req_valid, req_we;
   logic [0:0]  req_rank;
   logic [1:0]  req_bg, req_ba;
   logic [16:0] req_row;
   logic [9:0]  req_col;
   logic        req_ready, act_n, cke, rsp_valid, rsp_we;
   logic [16:0] A;
   logic [1:0]  bg, ba;
   logic [0:0]  cs_n;

   int          n_tests = 0;
   int          n_fail  = 0;

   int          exp_cmd [NCYC+1];
   logic [16:0] exp_a   [NCYC+1];
   int          exp_bg  [NCYC+1];
   int          exp_ba  [NCYC+1];
   int          exp_rdy [NCYC+1];
   int          exp_cke [NCYC+1];
   bit          rst_tab [NCYC+1];
   bit          drv_v   [NCYC+1];
   bit          drv_we  [NCYC+1];
   logic [1:0]  drv_bg  [NCYC+1];
   logic [1:0]  drv_ba  [NCYC+1];
   logic [16:0] drv_row [NCYC+1];
   logic [9:0]  drv_col [NCYC+1];

   always #5 clk = ~clk;

   mc_cmd_issuer dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
      .req_row(req_row), .req_col(req_col),
      .act_n(act_n), .A(A), .bg(bg), .ba(ba), .cs_n(cs_n), .cke(cke),
      .rsp_valid(rsp_valid), .rsp_we(rsp_we)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [0:0] cs, input logic an, input logic [16:0] a);
      if (cs === 1'b1) begin
         return (an === 1'b1 && a === 17'h1FFFF) ? C_DESEL : C_BAD;
      end else if (cs !== 1'b0 || an === 1'bx || an === 1'bz) begin
         return C_BAD;
      end else if (an === 1'b0) begin
         return C_ACT;
      end else begin
         case ({a[16], a[15], a[14]})
            3'b010:  return (a[10] === 1'b1) ? C_PRA : C_PRE;
            3'b101:  return C_RD;
            3'b100:  return C_WR;
            3'b001:  return C_REF;
            default: return C_BAD;
         endcase
      end
   endfunction

   function automatic logic [16:0] cmd_a(input int code, input logic [16:0] arg);
      logic [16:0] a;
      a = 17'h1FFFF;
      case (code)
         C_ACT: a = arg;
         C_PRE: begin a[16] = 1'b0; a[15] = 1'b1; a[14] = 1'b0; a[10] = 1'b0; end
         C_PRA: begin a[16] = 1'b0; a[15] = 1'b1; a[14] = 1'b0; a[10] = 1'b1; end
         C_RD:  begin a[9:0] = arg[9:0]; a[16] = 1'b1; a[15] = 1'b0; a[14] = 1'b1; a[10] = 1'b0; end
         C_WR:  begin a[9:0] = arg[9:0]; a[16] = 1'b1; a[15] = 1'b0; a[14] = 1'b0; a[10] = 1'b0; end
         C_REF: begin a[16] = 1'b0; a[15] = 1'b0; a[14] = 1'b1; end
         default: ;
      endcase
      return a;
   endfunction

   task automatic put_cmd(input int c, input int code, input logic [16:0] arg, input int bgv, input int bav);
      exp_cmd[c] = code;
      exp_a[c]   = cmd_a(code, arg);
      exp_bg[c]  = bgv;
      exp_ba[c]  = bav;
   endtask

   task automatic put_req(input int c0, input int c1, input bit we, input logic [1:0] bgv,
                          input logic [1:0] bav, input logic [16:0] row, input logic [9:0] col);
      for (int c = c0; c <= c1; c++) begin
         drv_v[c] = 1'b1;  drv_we[c] = we;  drv_bg[c] = bgv;
         drv_ba[c] = bav;  drv_row[c] = row; drv_col[c] = col;
      end
   endtask

   task automatic put_rdy(input int c0, input int c1, input int v);
      for (int c = c0; c <= c1; c++) exp_rdy[c] = v;
   endtask

   initial begin
      int code;
      int n_ref_all;
      int n_ref_win;
      n_ref_all = 0;
      n_ref_win = 0;
      for (int c = 0; c <= NCYC; c++) begin
         exp_cmd[c] = C_DESEL; exp_a[c] = 17'h1FFFF; exp_bg[c] = -1; exp_ba[c] = -1;
         exp_rdy[c] = -1; exp_cke[c] = 1; rst_tab[c] = 1'b1; drv_v[c] = 1'b0;
         drv_we[c] = 1'b0; drv_bg[c] = 2'd0; drv_ba[c] = 2'd0; drv_row[c] = 17'd0; drv_col[c] = 10'd0;
      end
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_rank = 1'b0;
      req_bg = 2'd0; req_ba = 2'd0; req_row = 17'd0; req_col = 10'd0;

      // reset held for edges 1..3: deselect, cke low, bg/ba zero, not ready
      rst_tab[1] = 1'b0; rst_tab[2] = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         exp_rdy[c] = 0; exp_cke[c] = 0; exp_bg[c] = 0; exp_ba[c] = 0;
      end
      put_rdy(B+1, B+1, 1);

      // closed read, then row-hit write, then row conflict
      put_req(B+1, B+1, 1'b0, 2'd1, 2'd2, 17'h00123, 10'h045);
      put_cmd(B+3,  C_ACT, 17'h00123, 1, 2);
      put_cmd(B+7,  C_RD,  17'h00045, 1, 2);
      put_rdy(B+2, B+6, 0); put_rdy(B+7, B+7, 1);
      put_req(B+8, B+8, 1'b1, 2'd1, 2'd2, 17'h00123, 10'h046);
      put_cmd(B+10, C_WR,  17'h00046, 1, 2);
      put_rdy(B+9, B+9, 0); put_rdy(B+10, B+10, 1);
      put_req(B+12, B+12, 1'b0, 2'd1, 2'd2, 17'h00200, 10'h047);
      put_cmd(B+14, C_PRE, 17'h00000, 1, 2);
      put_cmd(B+18, C_ACT, 17'h00200, 1, 2);
      put_cmd(B+22, C_RD,  17'h00047, 1, 2);
      put_rdy(B+13, B+21, 0); put_rdy(B+22, B+22, 1);

      // first timer wrap with a bank open; a held request lands as ready rises
      put_rdy(B+63, B+63, 1); put_rdy(B+64, B+77, 0); put_rdy(B+78, B+78, 1);
      put_cmd(B+66, C_PRA, 17'h00000, -1, -1);
      put_cmd(B+70, C_REF, 17'h00000, -1, -1);
      put_req(B+70, B+78, 1'b1, 2'd0, 2'd1, 17'h00500, 10'h011);
      put_cmd(B+80, C_ACT, 17'h00500, 0, 1);
      put_cmd(B+84, C_WR,  17'h00011, 0, 1);
      put_rdy(B+79, B+83, 0); put_rdy(B+84, B+84, 1);

      // bank closed by PRA, then a conflict straddling the second wrap
      put_req(B+100, B+100, 1'b0, 2'd1, 2'd2, 17'h00300, 10'h012);
      put_cmd(B+102, C_ACT, 17'h00300, 1, 2);
      put_cmd(B+106, C_RD,  17'h00012, 1, 2);
      put_rdy(B+101, B+105, 0); put_rdy(B+106, B+106, 1);
      put_req(B+124, B+124, 1'b0, 2'd1, 2'd2, 17'h00400, 10'h013);
      put_cmd(B+126, C_PRE, 17'h00000, 1, 2);
      put_cmd(B+130, C_ACT, 17'h00400, 1, 2);
      put_cmd(B+134, C_RD,  17'h00013, 1, 2);
      put_cmd(B+136, C_PRA, 17'h00000, -1, -1);
      put_cmd(B+140, C_REF, 17'h00000, -1, -1);
      put_rdy(B+125, B+147, 0); put_rdy(B+148, B+148, 1);

      // reset between ACT and RD drops the request
      put_req(B+160, B+160, 1'b0, 2'd2, 2'd3, 17'h00600, 10'h014);
      put_cmd(B+162, C_ACT, 17'h00600, 2, 3);
      put_rdy(B+161, B+164, 0); put_rdy(B+165, NCYC, 1);
      rst_tab[B+163] = 1'b0;
      exp_cke[B+164] = 0; exp_bg[B+164] = 0; exp_ba[B+164] = 0;

      for (int c = 1; c <= NCYC; c++) begin
         @(negedge clk);
         code = decode(cs_n, act_n, A);
         check($sformatf("cmd@%0d", c), code, exp_cmd[c]);
         check($sformatf("A@%0d", c), A, exp_a[c]);
         check($sformatf("cs_n@%0d", c), cs_n, (exp_cmd[c] == C_DESEL) ? 1 : 0);
         check($sformatf("rsp_valid@%0d", c), rsp_valid,
               (exp_cmd[c] == C_RD || exp_cmd[c] == C_WR) ? 1 : 0);
         if (exp_cmd[c] == C_RD || exp_cmd[c] == C_WR)
            check($sformatf("rsp_we@%0d", c), rsp_we, (exp_cmd[c] == C_WR) ? 1 : 0);
         check($sformatf("cke@%0d", c), cke, exp_cke[c]);
         if (exp_rdy[c] >= 0) check($sformatf("ready@%0d", c), req_ready, exp_rdy[c]);
         if (exp_bg[c] >= 0) begin
            check($sformatf("bg@%0d", c), bg, exp_bg[c]);
            check($sformatf("ba@%0d", c), ba, exp_ba[c]);
         end
         if (code == C_REF) begin
            n_ref_all++;
            if (c >= B+125) n_ref_win++;
         end
         reset_n   = rst_tab[c];
         req_valid = drv_v[c];
         req_we    = drv_we[c];
         req_bg    = drv_bg[c];
         req_ba    = drv_ba[c];
         req_row   = drv_row[c];
         req_col   = drv_col[c];
      end
      check("ref_total", n_ref_all, 2);
      check("ref_after_conflict", n_ref_win, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
